// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte slicing helpers and the
// iterative substitution FSM encoding.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } isb_state_e;

    // Byte 0 sits at the MSB, so byte i occupies [127-8i -: 8].
    function automatic int unsigned byte_lsb(input int unsigned i);
        return AES_STATE_W - 8 * (i + 1);
    endfunction

    function automatic logic [7:0] get_byte(input logic [AES_STATE_W-1:0] s,
                                            input int unsigned i);
        return s[byte_lsb(i) +: 8];
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational AES inverse S-box (256-entry lookup).
module inv_s_box (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = INV_SBOX[x];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of the captured state
// per clock, then holds the result on a valid/ready output.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned STEPS = AES_NBYTES / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    isb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [AES_STATE_W-1:0] state_reg;
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];
    int unsigned            base;
    logic                   accept;
    logic                   step;

    assign base = 32'(cnt_q) * LANES;

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_in[k] = get_byte(state_reg, base + k);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        inv_s_box u_inv_s_box (
            .x(lane_in[k]),
            .y(lane_out[k])
        );
    end

    // in_ready is gated by rst_n so it stays low for the whole reset cycle.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    accept  = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            state_reg <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                state_reg <= in_state;
                cnt_q     <= '0;
            end else if (step) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    state_reg[byte_lsb(base + k) +: 8] <= lane_out[k];
                end
                cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    assign out_state = state_reg;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter across LANES = 1, 2, 4, 8, 16.
module tb_inv_sub_bytes_iter;

    localparam logic [7:0] FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_state;
    logic [4:0]   in_valid_v;
    logic [4:0]   in_ready_v;
    logic [4:0]   out_valid_v;
    logic [4:0]   out_ready_v;
    logic [4:0]   busy_v;
    logic [127:0] out_state_a [5];
    int unsigned  cyc = 0;
    int           passed = 0;
    int           total = 0;
    vec_t         tbl [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_v[g]),
            .in_ready (in_ready_v[g]),
            .in_state (in_state),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready_v[g]),
            .out_state(out_state_a[g]),
            .busy     (busy_v[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Push one state through instance idx; reports result and edges from accept to out_valid.
    task automatic run_one(input int idx, input logic [127:0] s,
                           output logic [127:0] res, output int lat);
        int  n;
        bit  got;
        @(negedge clk);
        n = 0;
        while (!in_ready_v[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_state        = s;
        in_valid_v[idx] = 1'b1;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid_v[idx] = 1'b0;
            if (out_valid_v[idx]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            check($sformatf("timeout L%0d", 1 << idx), 128'(got), 128'd1);
            res = 'x;
        end else begin
            res = out_state_a[idx];
            out_ready_v[idx] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready_v[idx] = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] res, s, e, snap;
        int           lat, bad, sent, got;
        int unsigned  tstamp [3];
        logic [127:0] rq [3];

        tbl[0] = '{128'h63636363_63636363_63636363_63636363, 128'h0};
        tbl[1] = '{128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'h00010203_04050607_08090a0b_0c0d0e0f};
        tbl[2] = '{128'h00ff16ed_00ff16ed_00ff16ed_00ff16ed, 128'h527dff53_527dff53_527dff53_527dff53};
        tbl[3] = '{128'hed16ff00_00000000_ffffffff_16161616, 128'h53ff7d52_52525252_7d7d7d7d_ffffffff};

        rst_n       = 1'b0;
        in_valid_v  = '0;
        out_ready_v = '0;
        in_state    = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 128'(in_ready_v), 128'h0);
        check("reset out_valid", 128'(out_valid_v), 128'h0);
        check("reset busy", 128'(busy_v), 128'h0);
        check("reset out_state L4", out_state_a[2], 128'h0);
        check("reset out_state L1", out_state_a[0], 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 128'(in_ready_v), 128'h1f);

        for (int unsigned i = 0; i < 4; i++) begin
            run_one(2, tbl[i].din, res, lat);
            check($sformatf("vec%0d data", i), res, tbl[i].exp);
            check($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
        end

        for (int unsigned idx = 0; idx < 5; idx++) begin
            for (int unsigned b = 0; b < 16; b++) begin
                for (int unsigned j = 0; j < 16; j++) begin
                    s[127 - 8*j -: 8] = FWD[b*16 + j];
                    e[127 - 8*j -: 8] = 8'(b*16 + j);
                end
                run_one(int'(idx), s, res, lat);
                check($sformatf("roundtrip L%0d blk%0d", 1 << idx, b), res, e);
                check($sformatf("latency L%0d blk%0d", 1 << idx, b), 128'(lat), 128'(16 >> idx));
            end
        end

        // Backpressure: hold out_ready low in DONE with in_valid kept high.
        @(negedge clk);
        in_state      = tbl[1].din;
        in_valid_v[2] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid_v[2]) break;
        end
        snap = out_state_a[2];
        check("bp data", snap, tbl[1].exp);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!out_valid_v[2] || out_state_a[2] !== snap || in_ready_v[2] || !busy_v[2]) bad++;
            @(negedge clk);
        end
        check("bp stall cycles bad", 128'(bad), 128'd0);
        out_ready_v[2] = 1'b1;
        in_valid_v[2]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready_v[2] = 1'b0;
        check("bp in_ready after handshake", 128'(in_ready_v[2]), 128'd1);
        check("bp out_valid after handshake", 128'(out_valid_v[2]), 128'd0);
        check("bp out_state held", out_state_a[2], tbl[1].exp);

        // Reset on the edge ending the 2nd SUB cycle.
        in_state      = tbl[1].din;
        in_valid_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst out_valid", 128'(out_valid_v[2]), 128'd0);
        check("midrst busy", 128'(busy_v[2]), 128'd0);
        check("midrst out_state", out_state_a[2], 128'h0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid_v[2]) bad++;
        end
        check("midrst stale completion", 128'(bad), 128'd0);
        run_one(2, tbl[3].din, res, lat);
        check("midrst next data", res, tbl[3].exp);

        // Back-to-back with in_valid and out_ready held high.
        sent = 0;
        got  = 0;
        out_ready_v[2] = 1'b1;
        for (int c = 0; c < 100 && got < 3; c++) begin
            @(negedge clk);
            if (out_valid_v[2]) begin
                rq[got]     = out_state_a[2];
                tstamp[got] = cyc;
                got++;
            end
            if (in_ready_v[2]) begin
                if (sent < 3) begin
                    in_state      = tbl[sent + 1].din;
                    in_valid_v[2] = 1'b1;
                    sent++;
                end else begin
                    in_valid_v[2] = 1'b0;
                end
            end
        end
        in_valid_v[2] = 1'b0;
        @(negedge clk);
        out_ready_v[2] = 1'b0;
        check("b2b count", 128'(got), 128'd3);
        if (got == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b data%0d", i), rq[i], tbl[i + 1].exp);
            end
            check("b2b gap01", 128'(tstamp[1] - tstamp[0]), 128'd6);
            check("b2b gap12", 128'(tstamp[2] - tstamp[1]), 128'd6);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
